mem_arbiter: RTL and testbench

- Shares the single RAM port between instruction fetch (iREN) and data access (dREN/dWEN) in the pipelined MIPS core.
- Sequences each access through a small FSM and returns registered one-cycle ihit/dhit pulses with load data.
- Those pulses are what advance the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline latches.
- Data side has priority; an optional guard prevents instruction-fetch starvation.

---
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and data access.
// Optional fetch-starvation guard enabled by defining ARB_STARVE_GUARD_EN.
`timescale 1ns/1ps

module mem_arbiter #(
    parameter int WORD_W     = 32,
    parameter int TIMEOUT    = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dhit,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              tmo_err
);

    // state  | meaning
    // IDLE   | no access in flight, arbitrating requests
    // I_ACC  | instruction read presented to RAM
    // D_ACC  | data read/write presented to RAM
    // RESP   | one-cycle hit/response, requests ignored
    typedef enum logic [1:0] {IDLE, I_ACC, D_ACC, RESP} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam int         WAIT_W     = $clog2(TIMEOUT + 1);

    state_t             state;
    logic [WORD_W-1:0]  addr_q;
    logic [WORD_W-1:0]  store_q;
    logic               wr_q;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               d_req;
    logic               grant_d;

    assign d_req = dREN | dWEN;

`ifdef ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    logic [STARVE_W-1:0] starve_cnt;

    // a waiting fetch wins once data has been granted STARVE_MAX times in a row
    assign grant_d = d_req && !(iREN && (starve_cnt == STARVE_W'(STARVE_MAX)));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_d && iREN)
                starve_cnt <= starve_cnt + 1'b1;
            else if (!grant_d && iREN)
                starve_cnt <= '0;
        end
    end
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            addr_q   <= '0;
            store_q  <= '0;
            wr_q     <= 1'b0;
            wait_cnt <= '0;
            ihit     <= 1'b0;
            dhit     <= 1'b0;
            iload    <= '0;
            dload    <= '0;
            tmo_err  <= 1'b0;
        end else begin
            ihit <= 1'b0;
            dhit <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state    <= D_ACC;
                        addr_q   <= daddr;
                        store_q  <= dstore;
                        wr_q     <= dWEN;
                        wait_cnt <= '0;
                    end else if (iREN) begin
                        state    <= I_ACC;
                        addr_q   <= iaddr;
                        wr_q     <= 1'b0;
                        wait_cnt <= '0;
                    end
                end
                I_ACC, D_ACC: begin
                    if (wait_cnt != WAIT_W'(TIMEOUT))
                        wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt == WAIT_W'(TIMEOUT - 1))
                        tmo_err <= 1'b1;
                    if (ramstate == RAM_ACCESS) begin
                        state <= RESP;
                        // a withdrawn (flushed) request finishes without a hit
                        if (state == I_ACC) begin
                            iload <= ramload;
                            ihit  <= iREN;
                        end else begin
                            if (!wr_q)
                                dload <= ramload;
                            dhit <= d_req;
                        end
                    end else if (ramstate == RAM_ERROR) begin
                        state <= IDLE;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ramREN   = (state == I_ACC) || ((state == D_ACC) && !wr_q);
    assign ramWEN   = (state == D_ACC) && wr_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, priority, error retry, flush,
// timeout, async reset and fetch starvation behaviour.
`timescale 1ns/1ps

module tb_mem_arbiter;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        ihit, dhit, ramREN, ramWEN, tmo_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_chk  = 0;
    int n_fail = 0;

    mem_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .tmo_err(tmo_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
        step();
        step();
        nRST = 1'b1;
    endtask

    int nd, ni, first_i;

    initial begin
        do_reset();
        chk("rst_ihit", 32'(ihit), 0);
        chk("rst_dhit", 32'(dhit), 0);
        chk("rst_ramen", {30'd0, ramREN, ramWEN}, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_tmo", 32'(tmo_err), 0);

        // fetch only, ACCESS on second access cycle
        iREN = 1; iaddr = 32'h100; ramstate = BUSY;
        step();
        chk("fetch_ren_c1", 32'(ramREN), 1);
        chk("fetch_addr", ramaddr, 32'h100);
        step();
        chk("fetch_ren_c2", 32'(ramREN), 1);
        chk("fetch_ihit_early", 32'(ihit), 0);
        ramstate = ACCESS; ramload = 32'h2002000A;
        step();
        chk("fetch_ihit", 32'(ihit), 1);
        chk("fetch_iload", iload, 32'h2002000A);
        chk("fetch_ren_resp", 32'(ramREN), 0);
        chk("fetch_dhit", 32'(dhit), 0);
        iREN = 0; ramstate = FREE;
        step();
        chk("fetch_ihit_pulse", 32'(ihit), 0);
        chk("fetch_iload_hold", iload, 32'h2002000A);

        // simultaneous: data wins
        iREN = 1; iaddr = 32'h104; dWEN = 1; daddr = 32'h80; dstore = 32'hDEADBEEF;
        ramstate = ACCESS; ramload = 32'h11111111;
        step();
        chk("sim_wen", 32'(ramWEN), 1);
        chk("sim_ren", 32'(ramREN), 0);
        chk("sim_addr", ramaddr, 32'h80);
        chk("sim_store", ramstore, 32'hDEADBEEF);
        step();
        chk("sim_dhit", 32'(dhit), 1);
        chk("sim_no_ihit", 32'(ihit), 0);
        dWEN = 0;
        step();
        chk("sim_dhit_pulse", 32'(dhit), 0);
        step();
        chk("sim_iacc_ren", 32'(ramREN), 1);
        chk("sim_iacc_addr", ramaddr, 32'h104);
        step();
        chk("sim_ihit", 32'(ihit), 1);
        chk("sim_iload", iload, 32'h11111111);
        iREN = 0; ramstate = FREE;
        step();

        // ERROR then retry
        dREN = 1; daddr = 32'h40; ramstate = ERROR;
        step();
        chk("err_ren", 32'(ramREN), 1);
        step();
        chk("err_no_hit", 32'(dhit), 0);
        chk("err_idle_ren", 32'(ramREN), 0);
        ramstate = ACCESS; ramload = 32'h1234;
        step();
        chk("err_regrant", 32'(ramREN), 1);
        step();
        chk("err_dhit", 32'(dhit), 1);
        chk("err_dload", dload, 32'h1234);
        dREN = 0; ramstate = FREE;
        step();
        chk("err_dhit_pulse", 32'(dhit), 0);

        // flush mid-access
        iREN = 1; iaddr = 32'h200; ramstate = BUSY;
        step();
        iREN = 0;
        step();
        chk("flush_still_acc", 32'(ramREN), 1);
        ramstate = ACCESS; ramload = 32'hCAFE;
        step();
        chk("flush_no_ihit", 32'(ihit), 0);
        ramstate = FREE;
        step();
        chk("flush_idle", 32'(ramREN), 0);
        chk("flush_no_ihit2", 32'(ihit), 0);

        // timeout then async reset mid-access
        dREN = 1; daddr = 32'h44; ramstate = BUSY;
        step();
        repeat (59) step();
        chk("tmo_before", 32'(tmo_err), 0);
        repeat (10) step();
        chk("tmo_set", 32'(tmo_err), 1);
        chk("tmo_waiting", 32'(ramREN), 1);
        #2 nRST = 1'b0;
        #1;
        chk("arst_ren", 32'(ramREN), 0);
        chk("arst_tmo", 32'(tmo_err), 0);
        chk("arst_addr", ramaddr, 0);
        chk("arst_dhit", 32'(dhit), 0);
        dREN = 0; ramstate = FREE;
        step();
        nRST = 1'b1;
        step();
        chk("arst_idle", 32'(ramREN), 0);

        // continuous data + fetch requests
        do_reset();
        dREN = 1; daddr = 32'h300; iREN = 1; iaddr = 32'h400;
        ramstate = ACCESS; ramload = 32'h55;
        nd = 0; ni = 0; first_i = -1;
        for (int c = 1; c <= 24; c++) begin
            step();
            if (ihit && dhit) chk("both_hits", 1, 0);
            if (ihit) begin
                ni++;
                if (first_i < 0) first_i = nd;
            end
            if (dhit) nd++;
        end
`ifdef ARB_STARVE_GUARD_EN
        chk("starve_d_before_i", 32'(first_i), 4);
        chk("starve_i_count", 32'(ni), 1);
        chk("starve_d_total", 32'(nd), 7);
`else
        chk("strict_no_ihit", 32'(ni), 0);
        chk("strict_d_total", 32'(nd), 8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
